apb_bridge_ctrl: RTL and testbench

APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

---
 rtl/apb_bridge_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb_bridge_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: AHB-Lite slave to 4-slave APB bridge, one transfer in flight; APB_PREADY_EN adds Pready/Pslverr and a WAIT_MAX timeout.
// Latency: read completes 2 cycles after its address phase, write 3 (WDATA first); APB wait states add cycles when APB_PREADY_EN is defined.
// Backpressure: Hready_out stays low while a transfer is on the APB side; a new address phase is taken only on a cycle with Hready_out high.
module apb_bridge_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hsel,
    input  logic [1:0]  Htrans,
    input  logic        Hwrite,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic        Hready_in,
    output logic        Hready_out,
    output logic        Hresp,
    output logic [31:0] Hrdata,
    output logic [31:0] Paddr,
    output logic        Pwrite,
    output logic [31:0] Pwdata,
    output logic [3:0]  Psel,
    output logic        Penable,
    input  logic [31:0] Prdata_0,
    input  logic [31:0] Prdata_1,
    input  logic [31:0] Prdata_2,
`ifdef APB_PREADY_EN
    input  logic [3:0]  Pready,
    input  logic [3:0]  Pslverr,
`endif
    input  logic [31:0] Prdata_3
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           req_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             addr_vld;
    logic             accept;
    logic [3:0]       sel_oh;
    logic             slv_ready;
    logic             slv_err;
    logic             unused_htrans0;

    // NONSEQ and SEQ are treated alike, so only Htrans[1] matters
    assign unused_htrans0 = Htrans[0];
    assign addr_vld       = Hsel & Htrans[1] & Hready_in;

    // Slave select comes from the latched address so it holds through SETUP/ACCESS
    assign sel_oh = (Paddr[11:10] == 2'b00) ? (4'b0001 << Paddr[9:8]) : 4'b0000;

`ifdef APB_PREADY_EN
    assign slv_ready = |(Pready & sel_oh);
    assign slv_err   = |(Pslverr & sel_oh);
`else
    assign slv_ready = 1'b1;
    assign slv_err   = 1'b0;
`endif

    always_comb begin
        if (Haddr[11:10] != 2'b00) begin
            req_state = ERR1;
        end else if (Hwrite) begin
            req_state = WDATA;
        end else begin
            req_state = SETUP;
        end
    end

    always_comb begin
        case (Paddr[11:8])
            4'd0:    Hrdata = Prdata_0;
            4'd1:    Hrdata = Prdata_1;
            4'd2:    Hrdata = Prdata_2;
            4'd3:    Hrdata = Prdata_3;
            default: Hrdata = 32'h0000_0000;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        Hready_out   = 1'b1;
        Hresp        = 1'b0;
        Psel         = 4'b0000;
        Penable      = 1'b0;
        unique case (state)
            IDLE: begin
                accept    = addr_vld;
                state_nxt = addr_vld ? req_state : IDLE;
            end
            WDATA: begin
                Hready_out = 1'b0;
                state_nxt  = SETUP;
            end
            SETUP: begin
                Hready_out   = 1'b0;
                Psel         = sel_oh;
                wait_cnt_nxt = '0;
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                Psel    = sel_oh;
                Penable = 1'b1;
                if (slv_ready && !slv_err) begin
                    accept    = addr_vld;
                    state_nxt = addr_vld ? req_state : IDLE;
                end else begin
                    // Slave error or exhausted wait budget both turn into an AHB error
                    Hready_out = 1'b0;
                    if (slv_ready || (wait_cnt == CNT_LAST)) begin
                        state_nxt = ERR1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            ERR1: begin
                Hready_out = 1'b0;
                Hresp      = 1'b1;
                state_nxt  = ERR2;
            end
            ERR2: begin
                Hresp     = 1'b1;
                accept    = addr_vld;
                state_nxt = addr_vld ? req_state : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            Paddr    <= 32'h0000_0000;
            Pwrite   <= 1'b0;
            Pwdata   <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
            end
            if (state == WDATA) begin
                Pwdata <= Hwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb_apb_bridge_ctrl: transaction-level model expands each AHB request into its expected per-cycle
// bridge outputs; one compare task checks every cycle, literal checks pin the model on known transfers.
module tb_apb_bridge_ctrl;
    localparam int WAIT_MAX = 15;
    localparam int MAXC     = 512;

    logic        Hclk, Hresetn, Hsel, Hwrite, Hready_in, Hready_out, Hresp, Pwrite, Penable;
    logic [1:0]  Htrans;
    logic [31:0] Haddr, Hwdata, Hrdata, Paddr, Pwdata;
    logic [3:0]  Psel;
    logic [31:0] Prdata_0, Prdata_1, Prdata_2, Prdata_3;
`ifdef APB_PREADY_EN
    logic [3:0]  Pready, Pslverr;
`endif

    apb_bridge_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(Hsel), .Htrans(Htrans), .Hwrite(Hwrite),
        .Haddr(Haddr), .Hwdata(Hwdata), .Hready_in(Hready_in), .Hready_out(Hready_out),
        .Hresp(Hresp), .Hrdata(Hrdata), .Paddr(Paddr), .Pwrite(Pwrite), .Pwdata(Pwdata),
        .Psel(Psel), .Penable(Penable), .Prdata_0(Prdata_0), .Prdata_1(Prdata_1),
        .Prdata_2(Prdata_2),
`ifdef APB_PREADY_EN
        .Pready(Pready), .Pslverr(Pslverr),
`endif
        .Prdata_3(Prdata_3)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    typedef struct packed {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic        hready_in;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [3:0]  pready;
        logic [3:0]  pslverr;
    } inp_t;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [3:0]  psel;
        logic        pen;
        logic        chk_p;
        logic [31:0] paddr;
        logic        pwrite;
        logic        chk_wd;
        logic [31:0] pwdata;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    inp_t        in_a [MAXC];
    exp_t        ex_a [MAXC];
    int          n_cyc;
    logic [3:0]  rec_psel  [MAXC];
    logic        rec_rdy   [MAXC];
    logic        rec_resp  [MAXC];
    logic        rec_pen   [MAXC];
    logic [31:0] rec_rdata [MAXC];
    logic [31:0] rec_pwdata[MAXC];
    int          n_checks;
    int          n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic inp_t idle_in();
        inp_t v;
        v = '0;
        v.hready_in = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic rdy, input logic resp, input logic [3:0] psel, input logic pen);
        exp_t e;
        e = '0;
        e.rdy = rdy; e.resp = resp; e.psel = psel; e.pen = pen;
        return e;
    endfunction

    task automatic push(input inp_t v, input exp_t e);
        if (n_cyc < MAXC) begin
            in_a[n_cyc] = v;
            ex_a[n_cyc] = e;
            n_cyc++;
        end
    endtask

    task automatic add_idle(input inp_t v);
        push(v, mk_exp(1'b1, 1'b0, 4'b0000, 1'b0));
    endtask

    // Address phase rides on the previous (ready) cycle; returns index of the first cycle after it.
    task automatic add_txn(input logic wr, input logic [1:0] tr, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits, input logic serr, output int first);
        logic [3:0] idx;
        logic [3:0] oh;
        exp_t       e;
        inp_t       v;
        idx = addr[11:8];
        oh  = (idx < 4'd4) ? (4'b0001 << idx[1:0]) : 4'b0000;
        in_a[n_cyc-1].hsel   = 1'b1;
        in_a[n_cyc-1].htrans = tr;
        in_a[n_cyc-1].hwrite = wr;
        in_a[n_cyc-1].haddr  = addr;
        first = n_cyc;
        if (idx >= 4'd4) begin
            e = mk_exp(1'b0, 1'b1, 4'b0000, 1'b0);
            e.chk_rd = 1'b1;
            e.rdata  = 32'h0000_0000;
            push(idle_in(), e);
            push(idle_in(), mk_exp(1'b1, 1'b1, 4'b0000, 1'b0));
        end else begin
            if (wr) begin
                v = idle_in();
                v.hwdata = wd;
                push(v, mk_exp(1'b0, 1'b0, 4'b0000, 1'b0));
            end
            e = mk_exp(1'b0, 1'b0, oh, 1'b0);
            e.chk_p = 1'b1; e.paddr = addr; e.pwrite = wr;
            e.chk_wd = wr;  e.pwdata = wd;
            push(idle_in(), e);
            e.pen = 1'b1;
`ifdef APB_PREADY_EN
            v = idle_in();
            v.pready  = ~oh;
            v.pslverr = ~oh;
            for (int k = 0; k < waits && k < WAIT_MAX; k++) push(v, e);
            if (waits >= WAIT_MAX) begin
                push(idle_in(), mk_exp(1'b0, 1'b1, 4'b0000, 1'b0));
                push(idle_in(), mk_exp(1'b1, 1'b1, 4'b0000, 1'b0));
            end else begin
                v.pready  = oh;
                v.pslverr = serr ? oh : 4'b0000;
                e.rdy     = !serr;
                e.chk_rd  = !wr && !serr;
                e.rdata   = {28'hCAFE_000, idx};
                push(v, e);
                if (serr) begin
                    push(idle_in(), mk_exp(1'b0, 1'b1, 4'b0000, 1'b0));
                    push(idle_in(), mk_exp(1'b1, 1'b1, 4'b0000, 1'b0));
                end
            end
`else
            e.rdy    = (waits == 0) && !serr;
            e.chk_rd = !wr;
            e.rdata  = {28'hCAFE_000, idx};
            push(idle_in(), e);
`endif
        end
    endtask

    task automatic apply(input inp_t v);
        Hsel = v.hsel; Htrans = v.htrans; Hwrite = v.hwrite; Hready_in = v.hready_in;
        Haddr = v.haddr; Hwdata = v.hwdata;
`ifdef APB_PREADY_EN
        Pready = v.pready; Pslverr = v.pslverr;
`endif
    endtask

    task automatic compare(input int i);
        exp_t e;
        e = ex_a[i];
        rec_psel[i] = Psel; rec_rdy[i] = Hready_out; rec_resp[i] = Hresp;
        rec_pen[i] = Penable; rec_rdata[i] = Hrdata; rec_pwdata[i] = Pwdata;
        chk($sformatf("cyc%0d_hready_out", i), 32'(Hready_out), 32'(e.rdy));
        chk($sformatf("cyc%0d_hresp", i), 32'(Hresp), 32'(e.resp));
        chk($sformatf("cyc%0d_psel", i), 32'(Psel), 32'(e.psel));
        chk($sformatf("cyc%0d_penable", i), 32'(Penable), 32'(e.pen));
        if (e.chk_p) begin
            chk($sformatf("cyc%0d_paddr", i), Paddr, e.paddr);
            chk($sformatf("cyc%0d_pwrite", i), 32'(Pwrite), 32'(e.pwrite));
        end
        if (e.chk_wd) chk($sformatf("cyc%0d_pwdata", i), Pwdata, e.pwdata);
        if (e.chk_rd) chk($sformatf("cyc%0d_hrdata", i), Hrdata, e.rdata);
    endtask

    initial begin
        inp_t v;
        int   r_i, w_i, u_i, b_i, tmp;
`ifdef APB_PREADY_EN
        int   p_i, t_i;
`endif
        n_checks = 0; n_fail = 0; n_cyc = 0;
        Prdata_0 = 32'hCAFE_0000; Prdata_1 = 32'hCAFE_0001;
        Prdata_2 = 32'hCAFE_0002; Prdata_3 = 32'hCAFE_0003;
        Hresetn = 1'b0;
        apply(idle_in());

        add_idle(idle_in());
        add_txn(1'b0, 2'b10, 32'h0000_0200, 32'h0, 0, 1'b0, r_i);
        add_idle(idle_in());
        add_txn(1'b1, 2'b10, 32'h0000_0100, 32'h1234_5678, 0, 1'b0, w_i);
        in_a[w_i].hsel = 1'b1; in_a[w_i].htrans = 2'b10; in_a[w_i].haddr = 32'h0000_0500;
        add_idle(idle_in());
        add_txn(1'b0, 2'b10, 32'h0000_0500, 32'h0, 0, 1'b0, u_i);
        v = idle_in(); v.hsel = 1'b1; v.htrans = 2'b10; v.hready_in = 1'b0; v.haddr = 32'h200; add_idle(v);
        v = idle_in(); v.hsel = 1'b1; v.htrans = 2'b01; v.haddr = 32'h200; add_idle(v);
        v = idle_in(); v.hsel = 1'b0; v.htrans = 2'b10; v.haddr = 32'h200; add_idle(v);
        add_idle(idle_in());
        add_txn(1'b0, 2'b10, 32'h0000_0000, 32'h0, 0, 1'b0, b_i);
        add_txn(1'b0, 2'b11, 32'h0000_0300, 32'h0, 0, 1'b0, tmp);
        add_txn(1'b1, 2'b10, 32'h0000_03A0, 32'hA5A5_0003, 0, 1'b0, tmp);
        add_txn(1'b0, 2'b10, 32'h0000_04FC, 32'h0, 0, 1'b0, tmp);
        add_txn(1'b1, 2'b11, 32'h0000_0F04, 32'hDEAD_BEEF, 0, 1'b0, tmp);
        add_txn(1'b0, 2'b10, 32'h0000_0104, 32'h0, 0, 1'b0, tmp);
        add_idle(idle_in());
`ifdef APB_PREADY_EN
        add_txn(1'b0, 2'b10, 32'h0000_0100, 32'h0, 3, 1'b0, p_i);
        add_idle(idle_in());
        add_txn(1'b0, 2'b10, 32'h0000_0200, 32'h0, 20, 1'b0, t_i);
        add_idle(idle_in());
        add_txn(1'b1, 2'b10, 32'h0000_0300, 32'h0BAD_0BAD, 1, 1'b1, tmp);
        add_idle(idle_in());
`endif
        add_idle(idle_in());

        @(posedge Hclk); #1;
        chk("reset_psel", 32'(Psel), 32'h0);
        chk("reset_penable", 32'(Penable), 32'h0);
        chk("reset_hready_out", 32'(Hready_out), 32'h1);
        chk("reset_hresp", 32'(Hresp), 32'h0);
        chk("reset_paddr", Paddr, 32'h0);
        chk("reset_pwdata", Pwdata, 32'h0);
        chk("reset_pwrite", 32'(Pwrite), 32'h0);
        @(posedge Hclk); #1;
        Hresetn = 1'b1;

        for (int i = 0; i < n_cyc; i++) begin
            apply(in_a[i]);
            @(negedge Hclk);
            compare(i);
            @(posedge Hclk); #1;
        end

        chk("read_setup_psel", 32'(rec_psel[r_i]), 32'(4'b0100));
        chk("read_access_psel", 32'(rec_psel[r_i+1]), 32'(4'b0100));
        chk("read_access_hready", 32'(rec_rdy[r_i+1]), 32'h1);
        chk("read_hrdata", rec_rdata[r_i+1], 32'hCAFE_0002);
        chk("write_wdata_hready", 32'(rec_rdy[w_i]), 32'h0);
        chk("write_setup_hready", 32'(rec_rdy[w_i+1]), 32'h0);
        chk("write_access_hready", 32'(rec_rdy[w_i+2]), 32'h1);
        chk("write_setup_pwdata", rec_pwdata[w_i+1], 32'h1234_5678);
        chk("write_setup_psel", 32'(rec_psel[w_i+1]), 32'(4'b0010));
        chk("write_access_psel", 32'(rec_psel[w_i+2]), 32'(4'b0010));
        chk("unmapped_err1", {rec_rdy[u_i], rec_resp[u_i], rec_psel[u_i]}, 32'(6'b01_0000));
        chk("unmapped_err2", {rec_rdy[u_i+1], rec_resp[u_i+1], rec_psel[u_i+1]}, 32'(6'b11_0000));
        chk("b2b_psel", {rec_psel[b_i], rec_psel[b_i+1], rec_psel[b_i+2], rec_psel[b_i+3]}, 32'h0000_1188);
`ifdef APB_PREADY_EN
        chk("wait_hready_low", {rec_rdy[p_i], rec_rdy[p_i+1], rec_rdy[p_i+2], rec_rdy[p_i+3]}, 32'h0);
        chk("wait_hready_done", 32'(rec_rdy[p_i+4]), 32'h1);
        chk("timeout_last_access_pen", 32'(rec_pen[t_i+15]), 32'h1);
        chk("timeout_err1", {rec_rdy[t_i+16], rec_resp[t_i+16], rec_psel[t_i+16], rec_pen[t_i+16]}, 32'(7'b01_0000_0));
`endif

        v = idle_in(); v.hsel = 1'b1; v.htrans = 2'b10; v.haddr = 32'h0000_0300;
        apply(v);
        @(posedge Hclk); #1;
        apply(idle_in());
        @(negedge Hclk);
        chk("rst_setup_psel", 32'(Psel), 32'(4'b1000));
        @(posedge Hclk); #1;
        @(negedge Hclk);
        chk("rst_access_penable", 32'(Penable), 32'h1);
        Hresetn = 1'b0;
        @(posedge Hclk); #1;
        chk("rst_after_psel", 32'(Psel), 32'h0);
        chk("rst_after_penable", 32'(Penable), 32'h0);
        chk("rst_after_hready_out", 32'(Hready_out), 32'h1);
        chk("rst_after_hresp", 32'(Hresp), 32'h0);
        chk("rst_after_paddr", Paddr, 32'h0);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
